iic_cfg_seq: RTL and testbench

Register-initialisation sequencer placed in front of `iic_drive`. It walks an external table of 16-bit-address register writes and issues one driver transaction per entry. Each write can optionally be read back and compared, and failed transactions are retried. The block reports done/fail to system control and owns the driver's command ports.

---
 rtl/iic_cfg_seq.sv | 211 +++++++++++++++++++++
 tb/tb_iic_cfg_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_cfg_seq.sv
// rtl/iic_cfg_seq.sv - register-initialisation sequencer in front of iic_drive
//
// Walks an external table of {reg[15:0], data[7:0]} entries and issues one
// driver write per entry, optionally followed by a read-back compare.
// Failed attempts are retried; done/fail are reported as levels.
// Entry 16'hFFFF ends the table, 16'hFFFE waits data*DLY_UNIT cycles.
//
// Ports:
//   clk_i, rst_n            clock, asynchronous active-low reset
//   cfg_start               start request (accepted when not busy)
//   tbl_idx / tbl_data      table index out, entry in (combinational lookup)
//   drv_*                   command/status interface of iic_drive
//   cfg_busy/done/fail      sequence status
//   fail_idx, err_cnt       index of failing entry, failed attempt count
module iic_cfg_seq #(
  parameter logic [7:0] DEV_ADDR  = 8'h3C,
  parameter int         TBL_LEN   = 16,
  parameter int         IDX_W     = 8,
  parameter int         GAP_CYC   = 16,
  parameter int         MAX_RETRY = 3,
  parameter int         BUSY_TO   = 64,
  parameter int         VERIFY    = 1,
  parameter int         DLY_UNIT  = 1024
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             cfg_start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [23:0]      tbl_data,
  output logic             drv_start_en,
  output logic             drv_wr_rd_flag,
  output logic [7:0]       drv_dev_addr,
  output logic [15:0]      drv_register,
  output logic [7:0]       drv_data_byte,
  input  logic             drv_busy,
  input  logic             drv_err,
  input  logic [7:0]       drv_rd_data,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_fail,
  output logic [IDX_W-1:0] fail_idx,
  output logic [7:0]       err_cnt
);

  localparam int DW = 8 + $clog2(DLY_UNIT);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE,
    S_CHECK, S_GAP, S_DELAY, S_DONE, S_FAIL
  } state_t;

  state_t           state;
  state_t           gap_tgt;
  logic [15:0]      reg_r;
  logic [7:0]       dat_r;
  logic             phase;      // 0 = write, 1 = read-back
  logic [3:0]       retry;
  logic             err_seen;
  logic [7:0]       rd_cap;
  logic [15:0]      tmr;        // shared by busy timeout and inter-transaction gap
  logic [DW-1:0]    dly;
  logic [IDX_W-1:0] idx_nxt;
  logic             chk_fail;

  assign idx_nxt  = tbl_idx + 1'b1;
  assign chk_fail = err_seen | (phase & (rd_cap != dat_r));

  // Command fields come straight from the entry registers, which only change
  // in FETCH (reg/data) and CHECK (phase), so they hold from ISSUE to CHECK.
  assign drv_dev_addr   = DEV_ADDR;
  assign drv_register   = reg_r;
  assign drv_data_byte  = dat_r;
  assign drv_wr_rd_flag = phase;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      gap_tgt      <= S_IDLE;
      reg_r        <= '0;
      dat_r        <= '0;
      phase        <= 1'b0;
      retry        <= '0;
      err_seen     <= 1'b0;
      rd_cap       <= '0;
      tmr          <= '0;
      dly          <= '0;
      tbl_idx      <= '0;
      drv_start_en <= 1'b0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_fail     <= 1'b0;
      fail_idx     <= '0;
      err_cnt      <= '0;
    end else begin
      drv_start_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (cfg_start) begin
            state    <= S_FETCH;
            tbl_idx  <= '0;
            retry    <= '0;
            err_cnt  <= '0;
            cfg_done <= 1'b0;
            cfg_fail <= 1'b0;
            fail_idx <= '0;
            cfg_busy <= 1'b1;
          end
        end
        S_FETCH: begin
          // Decode on the incoming entry so the request leaves one cycle later.
          reg_r <= tbl_data[23:8];
          dat_r <= tbl_data[7:0];
          phase <= 1'b0;
          if (tbl_data[23:8] == 16'hFFFF) begin
            state    <= S_DONE;
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
          end else if (tbl_data[23:8] == 16'hFFFE) begin
            state <= S_DELAY;
            dly   <= DW'(tbl_data[7:0]) * DW'(DLY_UNIT);
          end else begin
            state        <= S_ISSUE;
            drv_start_en <= 1'b1;
          end
        end
        S_ISSUE: begin
          err_seen <= 1'b0;
          tmr      <= '0;
          state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (drv_busy) begin
            err_seen <= err_seen | drv_err;
            rd_cap   <= drv_rd_data;
            state    <= S_WAIT_DONE;
          end else if (tmr == 16'(BUSY_TO - 1)) begin
            err_seen <= 1'b1;
            state    <= S_CHECK;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          // Driver clears err/rd_data on return to idle: capture only while busy.
          if (drv_busy) begin
            err_seen <= err_seen | drv_err;
            rd_cap   <= drv_rd_data;
          end else begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          tmr <= '0;
          if (chk_fail) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            if (retry < 4'(MAX_RETRY)) begin
              retry   <= retry + 1'b1;
              phase   <= 1'b0;
              gap_tgt <= S_ISSUE;
              state   <= S_GAP;
            end else begin
              fail_idx <= tbl_idx;
              cfg_fail <= 1'b1;
              cfg_busy <= 1'b0;
              state    <= S_FAIL;
            end
          end else if (!phase && (VERIFY != 0)) begin
            phase   <= 1'b1;
            gap_tgt <= S_ISSUE;
            state   <= S_GAP;
          end else begin
            tbl_idx <= idx_nxt;
            retry   <= '0;
            if (idx_nxt == IDX_W'(TBL_LEN)) begin
              state    <= S_DONE;
              cfg_done <= 1'b1;
              cfg_busy <= 1'b0;
            end else begin
              gap_tgt <= S_FETCH;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (tmr == 16'(GAP_CYC - 1)) begin
            state <= gap_tgt;
            if (gap_tgt == S_ISSUE) drv_start_en <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_DELAY: begin
          if (dly == '0) begin
            tbl_idx <= idx_nxt;
            if (idx_nxt == IDX_W'(TBL_LEN)) begin
              state    <= S_DONE;
              cfg_done <= 1'b1;
              cfg_busy <= 1'b0;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            dly <= dly - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_cfg_seq.sv
// tb/tb_iic_cfg_seq.sv - self-checking bench for iic_cfg_seq
//
// Purpose: drives iic_cfg_seq against a small iic_drive/slave model and
// compares every driver transaction and final status with a table-level
// reference model.
// Ports: none (top-level bench).
module tb_iic_cfg_seq;

  localparam int TL   = 4;
  localparam int MAXR = 3;

  typedef struct {
    bit          rd;
    bit [15:0]   r;
    bit [7:0]    d;
    int unsigned t;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  tbl_idx;
  logic [23:0] tbl_data;
  logic        drv_start_en;
  logic        drv_wr_rd_flag;
  logic [7:0]  drv_dev_addr;
  logic [15:0] drv_register;
  logic [7:0]  drv_data_byte;
  logic        drv_busy;
  logic        drv_err;
  logic [7:0]  drv_rd_data;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_fail;
  logic [7:0]  fail_idx;
  logic [7:0]  err_cnt;

  iic_cfg_seq #(.TBL_LEN(TL), .MAX_RETRY(MAXR)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .cfg_start(cfg_start),
    .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .drv_start_en(drv_start_en), .drv_wr_rd_flag(drv_wr_rd_flag),
    .drv_dev_addr(drv_dev_addr), .drv_register(drv_register),
    .drv_data_byte(drv_data_byte), .drv_busy(drv_busy), .drv_err(drv_err),
    .drv_rd_data(drv_rd_data), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_fail(cfg_fail), .fail_idx(fail_idx), .err_cnt(err_cnt)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Table and slave-model knobs
  logic [23:0] tbl [TL];
  bit          mute = 1'b0;
  logic [15:0] nack_reg = 16'hFFFF;
  int          nack_cfg = 0;
  logic [15:0] bad_reg = 16'hFFFF;

  always_comb begin
    tbl_data = 24'h0;
    if (tbl_idx < 8'(TL)) tbl_data = tbl[tbl_idx[1:0]];
  end

  // Driver + slave model
  txn_t        log_q[$];
  int          nack_seen = 0;
  int          bcnt = 0;
  logic [7:0]  last_wr = 8'h00;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      drv_busy    <= 1'b0;
      drv_err     <= 1'b0;
      drv_rd_data <= 8'h00;
      bcnt        <= 0;
    end else begin
      if (cfg_start && !cfg_busy) begin
        log_q.delete();
        nack_seen <= 0;
      end
      if (drv_start_en)
        log_q.push_back(txn_t'{drv_wr_rd_flag, drv_register, drv_data_byte, cyc});
      if (drv_busy) begin
        if (bcnt == 0) begin
          drv_busy    <= 1'b0;
          drv_err     <= 1'b0;
          drv_rd_data <= 8'h00;
        end else begin
          bcnt <= bcnt - 1;
        end
      end else if (drv_start_en && !mute) begin
        drv_busy <= 1'b1;
        bcnt     <= $urandom_range(4, 1);
        if (!drv_wr_rd_flag) begin
          last_wr <= drv_data_byte;
          drv_err <= (drv_register == nack_reg) && (nack_seen < nack_cfg);
          if (drv_register == nack_reg) nack_seen <= nack_seen + 1;
        end else begin
          drv_err     <= 1'b0;
          drv_rd_data <= (drv_register == bad_reg) ? 8'h00 : last_wr;
        end
      end
    end
  end

  // Checking
  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: walks the table entry by entry
  txn_t exp_q[$];
  bit   exp_done, exp_fail;
  int   exp_fidx, exp_err, exp_idx;

  task automatic build_model();
    logic [15:0] r;
    logic [7:0]  d;
    int          tries, nl;
    bit          ok;
    exp_q.delete();
    exp_err = 0; exp_fail = 0; exp_fidx = 0; exp_idx = TL;
    nl = nack_cfg;
    for (int e = 0; e < TL; e++) begin
      r = tbl[e][23:8];
      d = tbl[e][7:0];
      if (r == 16'hFFFF) begin exp_idx = e; break; end
      if (r == 16'hFFFE) continue;
      tries = 0;
      forever begin
        exp_q.push_back(txn_t'{1'b0, r, d, 0});
        if (mute) ok = 0;
        else if (r == nack_reg && nl > 0) begin nl--; ok = 0; end
        else begin
          exp_q.push_back(txn_t'{1'b1, r, d, 0});
          ok = (r != bad_reg);
        end
        if (ok) break;
        if (exp_err < 255) exp_err++;
        if (tries == MAXR) begin exp_fail = 1; exp_fidx = e; break; end
        tries++;
      end
      if (exp_fail) begin exp_idx = e; break; end
    end
    exp_done = !exp_fail;
  endtask

  task automatic pulse_start(output int unsigned c);
    @(negedge clk_i);
    cfg_start = 1'b1;
    c = cyc;
    @(negedge clk_i);
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(cfg_done || cfg_fail) && n < 20000) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_finished"}, 32'(cfg_done | cfg_fail), 1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_ntxn"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s_t%0d_rd", tag, i), 32'(log_q[i].rd), 32'(exp_q[i].rd));
      chk($sformatf("%s_t%0d_reg", tag, i), 32'(log_q[i].r), 32'(exp_q[i].r));
      chk($sformatf("%s_t%0d_dat", tag, i), 32'(log_q[i].d), 32'(exp_q[i].d));
    end
    chk({tag, "_done"}, 32'(cfg_done), 32'(exp_done));
    chk({tag, "_fail"}, 32'(cfg_fail), 32'(exp_fail));
    chk({tag, "_busy"}, 32'(cfg_busy), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), exp_err);
    chk({tag, "_tbl_idx"}, 32'(tbl_idx), exp_idx);
    if (exp_fail) chk({tag, "_fail_idx"}, 32'(fail_idx), exp_fidx);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start_en"}, 32'(drv_start_en), 0);
    chk({tag, "_wr_rd"}, 32'(drv_wr_rd_flag), 0);
    chk({tag, "_dev_addr"}, 32'(drv_dev_addr), 32'h3C);
    chk({tag, "_register"}, 32'(drv_register), 0);
    chk({tag, "_data"}, 32'(drv_data_byte), 0);
    chk({tag, "_tbl_idx"}, 32'(tbl_idx), 0);
    chk({tag, "_busy"}, 32'(cfg_busy), 0);
    chk({tag, "_done"}, 32'(cfg_done), 0);
    chk({tag, "_fail"}, 32'(cfg_fail), 0);
    chk({tag, "_fail_idx"}, 32'(fail_idx), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
  endtask

  task automatic set_nominal();
    tbl[0] = {16'h3008, 8'h82};
    tbl[1] = {16'h3103, 8'h03};
    tbl[2] = {16'hFFFF, 8'h00};
    tbl[3] = {16'h0000, 8'h00};
    nack_reg = 16'hFFFF; nack_cfg = 0; bad_reg = 16'hFFFF; mute = 1'b0;
  endtask

  int unsigned c0;
  int          n;
  logic [7:0]  idx0;
  int          sel, fe;

  initial begin
    set_nominal();

    // Reset state
    repeat (3) @(negedge clk_i);
    check_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);
    check_reset_vals("post_rst");

    // Nominal run with start latency and an ignored start while running
    build_model();
    pulse_start(c0);
    n = 0;
    while (log_q.size() == 0 && n < 100) begin @(negedge clk_i); n++; end
    chk("nom_first_issue", 32'(log_q.size() > 0), 1);
    if (log_q.size() > 0) chk("start_latency", log_q[0].t - c0, 2);
    idx0 = tbl_idx;
    cfg_start = 1'b1;
    @(negedge clk_i);
    cfg_start = 1'b0;
    chk("ign_tbl_idx", 32'(tbl_idx), 32'(idx0));
    chk("ign_busy", 32'(cfg_busy), 1);
    wait_end("nom");
    check_run("nom");

    // Recovered NACK on entry 0's first write
    set_nominal();
    nack_reg = 16'h3008; nack_cfg = 1;
    build_model();
    pulse_start(c0);
    wait_end("nack");
    check_run("nack");

    // Persistent readback mismatch on entry 1
    set_nominal();
    bad_reg = 16'h3103;
    build_model();
    pulse_start(c0);
    wait_end("mism");
    check_run("mism");

    // Delay entry then a write then end marker
    set_nominal();
    tbl[0] = {16'hFFFE, 8'h02};
    tbl[1] = {16'h1234, 8'h55};
    build_model();
    pulse_start(c0);
    wait_end("dly");
    check_run("dly");
    if (log_q.size() > 0) begin
      chk("dly_quiet_min", 32'((log_q[0].t - c0) >= 2048), 1);
      chk("dly_quiet_max", 32'((log_q[0].t - c0) <= 2060), 1);
    end

    // Driver never goes busy: every attempt times out
    set_nominal();
    mute = 1'b1;
    build_model();
    pulse_start(c0);
    wait_end("tmo");
    check_run("tmo");
    for (int i = 1; i < log_q.size(); i++) begin
      chk($sformatf("tmo_gap%0d_min", i), 32'((log_q[i].t - log_q[i-1].t) >= 64), 1);
      chk($sformatf("tmo_gap%0d_max", i), 32'((log_q[i].t - log_q[i-1].t) <= 100), 1);
    end
    mute = 1'b0;

    // Reset while the driver is busy
    set_nominal();
    pulse_start(c0);
    n = 0;
    while (!drv_busy && n < 100) begin @(negedge clk_i); n++; end
    chk("rst_mid_busy_seen", 32'(drv_busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk_i);
    check_reset_vals("rst_mid_next");
    rst_n = 1'b1;
    @(negedge clk_i);

    // Randomised tables and fault injection
    for (int it = 0; it < 6; it++) begin
      for (int e = 0; e < TL; e++)
        tbl[e] = {4'(e), 12'($urandom), 8'($urandom_range(255, 1))};
      if ($urandom_range(2, 0) == 0) tbl[$urandom_range(3, 1)] = {16'hFFFF, 8'h00};
      sel = $urandom_range(2, 0);
      fe  = $urandom_range(3, 0);
      nack_reg = 16'hFFFF; nack_cfg = 0; bad_reg = 16'hFFFF; mute = 1'b0;
      if (sel == 1) begin nack_reg = tbl[fe][23:8]; nack_cfg = $urandom_range(4, 1); end
      if (sel == 2) bad_reg = tbl[fe][23:8];
      build_model();
      pulse_start(c0);
      wait_end($sformatf("rnd%0d", it));
      check_run($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
